// File: rtl/sevenseg_scan.sv
// Time-multiplexed common-anode seven-segment driver: hex decode, per-digit dp,
// optional leading-zero blanking and a double buffer that only swaps at frame end.
module sevenseg_scan #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  enable,
    input  logic                  lz_en,
    output logic [7:0]            segments,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CntMax = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IdxMax = IW'(DIGITS - 1);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
    logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                pend_q, pend_d;
    logic [7:0]          segments_q, segments_d;
    logic [DIGITS-1:0]   digit_sel_q, digit_sel_d;

    logic       tick;
    logic       last;
    logic       xfer;
    logic       blank;
    logic [3:0] nibble;
    logic [7:0] glyph;

    always_comb begin
        tick       = enable && (cnt_q == CntMax);
        last       = (idx_q == IdxMax);
        frame_done = tick && last;
        // While dark, pending data is pushed straight through every cycle.
        xfer       = pend_q && (!enable || frame_done);

        cnt_d = '0;
        idx_d = '0;
        if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            idx_d = idx_q;
            if (tick) begin
                idx_d = last ? '0 : idx_q + 1'b1;
            end
        end

        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_d      = pend_q;
        disp_data_d = disp_data_q;
        disp_dp_d   = disp_dp_q;
        if (xfer) begin
            disp_data_d = pend_data_q;
            disp_dp_d   = pend_dp_q;
            pend_d      = 1'b0;
        end
        if (load) begin
            pend_data_d = data_in;
            pend_dp_d   = dp_in;
            pend_d      = 1'b1;
        end
    end

    always_comb begin
        nibble = disp_data_q[4*idx_q +: 4];
        blank  = lz_en && (idx_q != '0) && ((disp_data_q >> (4 * idx_q)) == '0);

        glyph = 8'hFF;
        case (nibble)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            4'hF: glyph = 8'h8E;
            default: glyph = 8'hFF;
        endcase

        segments_d  = 8'hFF;
        digit_sel_d = '1;
        if (enable) begin
            segments_d = {~disp_dp_q[idx_q], blank ? 7'h7F : glyph[6:0]};
            // Keep all digits dark on count 0 so the slot change never ghosts.
            if (cnt_d != '0) begin
                digit_sel_d = ~(DIGITS'(1) << idx_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_q      <= 1'b0;
            disp_data_q <= '0;
            disp_dp_q   <= '0;
            segments_q  <= 8'hFF;
            digit_sel_q <= '1;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_q      <= pend_d;
            disp_data_q <= disp_data_d;
            disp_dp_q   <= disp_dp_d;
            segments_q  <= segments_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    assign segments  = segments_q;
    assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan: expected digit slots are queued when
// stimulus is driven and compared as each lit slot appears on the display pins.
module tb_sevenseg_scan;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        enable = 1'b0;
    logic        lz_en = 1'b0;
    logic [7:0]  segments;
    logic [3:0]  digit_sel;
    logic        frame_done;

    sevenseg_scan #(
        .DIGITS  (DIGITS),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .enable     (enable),
        .lz_en      (lz_en),
        .segments   (segments),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [11:0] sb[$];
    logic [11:0] exp_slot;
    logic        mon_on = 1'b0;
    logic [3:0]  prev_sel = 4'hF;
    int          run_len = 0;
    int          last_fd = 0;
    logic        fd_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    task automatic push_frame(input logic [15:0] d, input logic [3:0] dp, input logic lz);
        for (int i = 0; i < 4; i++) begin
            logic [7:0]  s;
            logic [15:0] hi;
            logic [3:0]  sel;
            hi = d >> (4 * i);
            s  = hex_seg(hi[3:0]);
            if (lz && i > 0 && hi == 16'h0) s = 8'hFF;
            s[7] = ~dp[i];
            sel  = ~(4'b0001 << i);
            sb.push_back({sel, s});
        end
    endtask

    // Monitor: compare the first cycle of every lit slot, then its length.
    always @(negedge clk) begin
        if (mon_on) begin
            if (digit_sel != 4'hF) begin
                if (prev_sel == 4'hF) begin
                    if (sb.size() == 0) begin
                        check_eq("sb_empty", sb.size(), 1);
                    end else begin
                        exp_slot = sb.pop_front();
                        check_eq("slot", {20'h0, digit_sel, segments}, {20'h0, exp_slot});
                    end
                    run_len <= 1;
                end else begin
                    run_len <= run_len + 1;
                end
            end else if (prev_sel != 4'hF) begin
                check_eq("lit_len", run_len, CLK_DIV - 1);
            end
            if (frame_done) begin
                if (fd_seen) check_eq("frame_period", cyc - last_fd, DIGITS * CLK_DIV);
                fd_seen <= 1'b1;
                last_fd <= cyc;
            end
        end else begin
            fd_seen <= 1'b0;
        end
        prev_sel <= digit_sel;
    end

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
        data_in = d;
        dp_in   = dp;
        load    = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic wait_frame_done();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_done && k < 100);
        if (!frame_done) check_eq("fd_timeout", frame_done, 1);
    endtask

    task automatic wait_sel(input logic [3:0] v);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (digit_sel != v && k < 100);
        if (digit_sel != v) check_eq("sel_timeout", digit_sel, v);
    endtask

    task automatic start_scan();
        mon_on = 1'b1;
        enable = 1'b1;
    endtask

    task automatic stop_scan();
        @(posedge clk);
        #1 enable = 1'b0;
        mon_on = 1'b0;
        check_eq("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and idle with enable low.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_seg", segments, 8'hFF);
        check_eq("rst_sel", digit_sel, 4'hF);
        check_eq("rst_fd", frame_done, 0);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check_eq("idle_seg", segments, 8'hFF);
            check_eq("idle_sel", digit_sel, 4'hF);
            check_eq("idle_fd", frame_done, 0);
        end

        // Basic scan.
        @(posedge clk);
        #1 do_load(16'h12AF, 4'b0100);
        @(posedge clk);
        #1;
        push_frame(16'h12AF, 4'b0100, 1'b0);
        push_frame(16'h12AF, 4'b0100, 1'b0);
        start_scan();
        wait_frame_done();
        wait_frame_done();
        stop_scan();

        // Tear-free update: new data loaded at index 1 waits for frame end.
        do_load(16'h1234, 4'b0001);
        @(posedge clk);
        #1;
        push_frame(16'h1234, 4'b0001, 1'b0);
        push_frame(16'h5678, 4'b0010, 1'b0);
        start_scan();
        wait_sel(4'b1101);
        do_load(16'h5678, 4'b0010);
        wait_frame_done();
        wait_frame_done();
        stop_scan();

        // Load colliding with the frame-end transfer.
        push_frame(16'h5678, 4'b0010, 1'b0);
        push_frame(16'h1111, 4'b1000, 1'b0);
        push_frame(16'h0001, 4'b0000, 1'b0);
        start_scan();
        wait_sel(4'b1101);
        do_load(16'h1111, 4'b1000);
        wait_frame_done();
        do_load(16'h0001, 4'b0000);
        wait_frame_done();
        wait_frame_done();
        stop_scan();

        // Leading-zero blanking on, then off.
        do_load(16'h0070, 4'b1000);
        @(posedge clk);
        #1 lz_en = 1'b1;
        push_frame(16'h0070, 4'b1000, 1'b1);
        push_frame(16'h0070, 4'b1000, 1'b0);
        start_scan();
        wait_frame_done();
        @(posedge clk);
        #1 lz_en = 1'b0;
        wait_frame_done();
        stop_scan();

        // Asynchronous reset mid-scan with data pending.
        do_load(16'h1234, 4'b0000);
        @(posedge clk);
        #1 enable = 1'b1;
        wait_sel(4'b1101);
        do_load(16'hABCD, 4'b1111);
        wait_sel(4'b1011);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_seg", segments, 8'hFF);
        check_eq("arst_sel", digit_sel, 4'hF);
        check_eq("arst_fd", frame_done, 0);
        @(posedge clk);
        #1;
        check_eq("arst_hold_seg", segments, 8'hFF);
        check_eq("arst_hold_sel", digit_sel, 4'hF);
        push_frame(16'h0000, 4'b0000, 1'b0);
        push_frame(16'h0000, 4'b0000, 1'b0);
        mon_on = 1'b1;
        rst_n  = 1'b1;
        wait_frame_done();
        wait_frame_done();
        stop_scan();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
